wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Write-back arbiter directly upstream of the 32x32 register file write port (d, wn, we).
- Merges two write sources onto the single port:
  - in-order pipeline write-back (fixed priority, never stalled);
  - long-latency unit results (mul/div, loads from slow memory), buffered in a small FIFO.
- Exports a per-register busy mask so decode can stall on pending long-latency writes.

Parameters:
DEPTH, 2, FIFO entries for long-latency results; power of 2, >=2
AW, 1, log2(DEPTH), FIFO pointer width

Ports:
clk  in  1  clock, all state updates on posedge
clrn  in  1  asynchronous active-low reset
p_we  in  1  pipeline write enable
p_wn  in  5  pipeline destination register
p_d  in  32  pipeline write data
l_valid  in  1  long-latency result valid
l_wn  in  5  long-latency destination register
l_d  in  32  long-latency result data
l_ready  out  1  arbiter can accept long-latency result this cycle
wb_we  out  1  register file write enable
wb_wn  out  5  register file write number
wb_d  out  32  register file write data
busy  out  32  bit r set = valid queued write pending to register r
count  out  AW+1  number of FIFO entries (valid or killed)

Behaviour:
- Reset (clrn=0, async): FIFO empty, pointers 0, all entry valid bits 0; count=0, busy=0.
- Reset gating: while clrn=0, l_ready=0 and wb_we=0 regardless of p_we.
- Reset mid-operation discards all queued results; no write emitted for them.
- Effective pipeline write: pw = p_we && (p_wn != 0).
  - p_we with p_wn=0 is ignored; the port is free for the FIFO that cycle.
- Output mux (combinational, zero latency):
  - pw: wb_we=1, wb_wn=p_wn, wb_d=p_d.
  - else, head entry present and valid: wb_we=1, wb_wn/wb_d from head.
  - else: wb_we=0; wb_wn and wb_d are 0.
- Pop: head popped on the posedge when either:
  - head valid and !pw (it was written); or
  - head killed (invalid), regardless of pw. Killed entries never assert wb_we.
- Push:
  - l_ready = (count < DEPTH); registered-count based, so no push-while-full even if a pop occurs that cycle.
  - Accept on l_valid && l_ready.
  - l_wn=0 is accepted (handshake completes) but not enqueued.
  - Otherwise the entry is enqueued with valid=1.
  - Push and pop in the same cycle: count unchanged.
- Kill (WAW ordering): on pw, every queued entry with wn==p_wn has its valid bit cleared at the posedge, because the pipeline write is architecturally newer.
  - Kill does not affect the entry being pushed in the same cycle; an arriving long result is treated as newer than the pipeline write.
- busy is combinational: OR over valid entries of a one-hot decode of wn. It reflects registered state only, not same-cycle l_valid. busy[0] is always 0.
- count is registered and ranges 0..DEPTH. Pointers wrap modulo DEPTH.
- Starvation of the FIFO under continuous pw is permitted; l_ready drops when full, and the upstream unit holds l_valid/l_wn/l_d stable until accepted.

Test Plan:
- Reset then idle: clrn pulse low mid-cycle -> wb_we=0, l_ready=1, count=0, busy=0 immediately (async).
- Pipeline only: p_we=1, p_wn=5, p_d=0x1234 -> same cycle wb_we=1, wb_wn=5, wb_d=0x1234. Then p_wn=0 -> wb_we=0.
- Buffer and drain:
  - Three l_valid pushes (wn=3/0xA, 4/0xB, 6/0xC) while pw held to r1, r2, r7 -> first two accepted, count=2, busy=0x18, l_ready=0, third held.
  - Drop pw -> wb writes r3=0xA, then r4=0xB, then third accepted and written r6=0xC. count returns 0.
- Kill:
  - Queue wn=9 data 0x55, same cycle pw to r2.
  - Next cycle pw p_wn=9 data 0x77 -> wb writes r9=0x77; entry killed; busy[9]=0 after edge.
  - Next cycle with no pw: killed entry pops with wb_we=0; count=0.
- Simultaneous push and pipeline same register: l_valid wn=8 data 0x1 with pw p_wn=8 data 0x2 -> r8=0x2 written now; entry stays valid; r8=0x1 written next cycle.
- Reset mid-operation: FIFO holding 2 valid entries, assert clrn=0 -> count=0, busy=0, no queued write ever appears on wb_we after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter: pipeline write-back has priority over a small FIFO of
// long-latency results; queued entries are killed by newer pipeline writes to the same register.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          p_we,
  input  logic [4:0]    p_wn,
  input  logic [31:0]   p_d,
  input  logic          l_valid,
  input  logic [4:0]    l_wn,
  input  logic [31:0]   l_d,
  output logic          l_ready,
  output logic          wb_we,
  output logic [4:0]    wb_wn,
  output logic [31:0]   wb_d,
  output logic [31:0]   busy,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]       q_wn [DEPTH];
  logic [31:0]      q_d  [DEPTH];
  logic [DEPTH-1:0] q_v;
  logic [AW-1:0]    rp, wp;
  logic [AW:0]      cnt;

  logic pw, has_head, head_v, push, enq, pop;

  assign count    = cnt;
  assign pw       = p_we && (p_wn != 5'd0);
  assign has_head = (cnt != '0);
  assign head_v   = has_head && q_v[rp];
  assign l_ready  = clrn && (cnt < FULL);
  assign push     = l_valid && l_ready;
  assign enq      = push && (l_wn != 5'd0);
  // Killed heads drain even while the pipeline owns the port.
  assign pop      = has_head && (!q_v[rp] || !pw);

  always_comb begin
    wb_we = 1'b0;
    wb_wn = 5'd0;
    wb_d  = 32'd0;
    if (clrn) begin
      if (pw) begin
        wb_we = 1'b1;
        wb_wn = p_wn;
        wb_d  = p_d;
      end else if (head_v) begin
        wb_we = 1'b1;
        wb_wn = q_wn[rp];
        wb_d  = q_d[rp];
      end
    end
  end

  always_comb begin
    busy = 32'd0;
    for (int i = 0; i < DEPTH; i++)
      if (q_v[i]) busy[q_wn[i]] = 1'b1;
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      q_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_wn[i] <= 5'd0;
        q_d[i]  <= 32'd0;
      end
    end else begin
      // Kill first so the entry pushed this cycle survives: it is newer than the pipeline write.
      if (pw)
        for (int i = 0; i < DEPTH; i++)
          if (q_wn[i] == p_wn) q_v[i] <= 1'b0;
      if (pop) begin
        q_v[rp] <= 1'b0;
        rp      <= rp + 1'b1;
      end
      if (enq) begin
        q_v[wp]  <= 1'b1;
        q_wn[wp] <= l_wn;
        q_d[wp]  <= l_d;
        wp       <= wp + 1'b1;
      end
      case ({enq, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
